// File: rtl/ps_pkg.sv
// Shared types and defaults for the pixel-stream frame-buffer blocks.
package ps_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIXEL_W      = 12;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } fbw_state_t;

endpackage

// File: rtl/ps_fb_writer.sv
// Writes whole frames of the valid-qualified pixel stream into a ping-pong frame buffer,
// publishes the latest complete bank and drops frames that would collide with the reader.
module ps_fb_writer
    import ps_pkg::*;
#(
    parameter int  H_ACTIVE   = H_ACTIVE_DEF,
    parameter int  V_ACTIVE   = V_ACTIVE_DEF,
    parameter int  DATA_WIDTH = PIXEL_W,
    localparam int FRAME_PIX  = H_ACTIVE * V_ACTIVE,
    localparam int IDX_W      = $clog2(FRAME_PIX)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_sof,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_active,
    input  logic                  i_rd_bank,
    output logic                  o_wr,
    output logic [IDX_W:0]        o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_frame_valid,
    output logic                  o_pub_bank,
    output logic                  o_frame_done,
    output logic                  o_err_short,
    output logic                  o_err_long,
    output logic [7:0]            o_drop_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIX - 1);

    fbw_state_t            state_q, state_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  long_seen_q, long_seen_d;
    logic                  wr_q, wr_d;
    logic [IDX_W:0]        waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  pub_bank_q, pub_bank_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_short_q, err_short_d;
    logic                  err_long_q, err_long_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d       = state_q;
        wr_bank_d     = wr_bank_q;
        idx_d         = idx_q;
        long_seen_d   = long_seen_q;
        wr_d          = 1'b0;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        frame_valid_d = frame_valid_q;
        pub_bank_d    = pub_bank_q;
        frame_done_d  = 1'b0;
        err_short_d   = 1'b0;
        err_long_d    = 1'b0;
        drop_cnt_d    = drop_cnt_q;

        // Start of frame overrides everything, including a pixel on the same cycle.
        if (i_sof) begin
            err_short_d = (state_q == WRITE);
            long_seen_d = 1'b0;
            idx_d       = '0;
            if (i_rd_active && (i_rd_bank == wr_bank_q)) begin
                state_d = DROP;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else begin
                state_d = WRITE;
            end
        end else begin
            case (state_q)
                WRITE: begin
                    if (i_valid) begin
                        wr_d    = 1'b1;
                        waddr_d = {wr_bank_q, idx_q};
                        wdata_d = i_data;
                        if (idx_q == LAST_IDX) begin
                            frame_done_d  = 1'b1;
                            pub_bank_d    = wr_bank_q;
                            frame_valid_d = 1'b1;
                            wr_bank_d     = ~wr_bank_q;
                            idx_d         = '0;
                            state_d       = IDLE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (i_valid && !long_seen_q) begin
                        err_long_d  = 1'b1;
                        long_seen_d = 1'b1;
                    end
                end
                DROP: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= IDLE;
            wr_bank_q     <= 1'b0;
            idx_q         <= '0;
            long_seen_q   <= 1'b0;
            wr_q          <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            frame_valid_q <= 1'b0;
            pub_bank_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            idx_q         <= idx_d;
            long_seen_q   <= long_seen_d;
            wr_q          <= wr_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            frame_valid_q <= frame_valid_d;
            pub_bank_q    <= pub_bank_d;
            frame_done_q  <= frame_done_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign o_wr          = wr_q;
    assign o_waddr       = waddr_q;
    assign o_wdata       = wdata_q;
    assign o_frame_valid = frame_valid_q;
    assign o_pub_bank    = pub_bank_q;
    assign o_frame_done  = frame_done_q;
    assign o_err_short   = err_short_q;
    assign o_err_long    = err_long_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule
